// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding for the scan chain load/capture/unload controller.
package scan_ctrl_pkg;

   localparam int unsigned ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter for shift/unload phases; last_o flags the final bit of a phase.
module scan_bit_counter #(
   parameter int unsigned CHAIN_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic last_o
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q;

   // Clear wins over increment; saturate at CHAIN_LEN so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < CNT_W'(CHAIN_LEN))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= (cnt_d == CNT_W'(CHAIN_LEN - 1));
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain driver/collector: serial load, one capture clock, serial unload.
// Optional SCAN_COMPARE_EN adds an expected-data compare with a mismatch flag.
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 8
) (
   input  logic                 CK,
   input  logic                 RN,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] load_data,
`ifdef SCAN_COMPARE_EN
   input  logic [CHAIN_LEN-1:0] exp_data,
   output logic                 mismatch,
`endif
   input  logic                 so,
   output logic                 se,
   output logic                 si,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] unload_data
);

   state_e               state_q, state_d;
   logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
   logic [CHAIN_LEN-1:0] collect_q, collect_d;
   logic [CHAIN_LEN-1:0] unload_q, unload_d;
   logic                 se_q, se_d;
   logic                 si_q, si_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 cnt_clr, cnt_inc, cnt_last;
`ifdef SCAN_COMPARE_EN
   logic                 mismatch_q, mismatch_d;
`endif

   scan_bit_counter #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_cnt (
      .clk_i  (CK),
      .rst_ni (RN),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .last_o (cnt_last)
   );

   // Next state, datapath and next-cycle output decode.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      collect_d = collect_q;
      unload_d  = unload_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
`ifdef SCAN_COMPARE_EN
      mismatch_d = mismatch_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d = load_data;
               cnt_clr = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_d = shreg_q >> 1;
            cnt_inc = 1'b1;
            if (cnt_last) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            cnt_clr = 1'b0 | 1'b1;
            state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            // First so bit ends up in bit 0 after CHAIN_LEN right-shifts.
            collect_d = {so, collect_q[CHAIN_LEN-1:1]};
            cnt_inc   = 1'b1;
            if (cnt_last) begin
               unload_d = collect_d;
`ifdef SCAN_COMPARE_EN
               mismatch_d = |(collect_d ^ exp_data);
`endif
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      se_d   = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      si_d   = (state_d == ST_SHIFT) ? shreg_d[0] : 1'b0;
      busy_d = (state_d == ST_SHIFT) || (state_d == ST_CAPTURE) || (state_d == ST_UNLOAD);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         collect_q <= '0;
         unload_q  <= '0;
         se_q      <= 1'b0;
         si_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         collect_q <= collect_d;
         unload_q  <= unload_d;
         se_q      <= se_d;
         si_q      <= si_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef SCAN_COMPARE_EN
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;
`endif

   assign se          = se_q;
   assign si          = si_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign unload_data = unload_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving a modelled chain of scan flops (RN=SN=1).
module tb_scan_chain_ctrl;

   localparam int unsigned N = 8;
   localparam int          W = 2 * N + 6;

   logic         CK = 1'b0;
   logic         RN = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] load_data = '0;
   logic         so;
   logic         se, si, busy, done;
   logic [N-1:0] unload_data;
`ifdef SCAN_COMPARE_EN
   logic [N-1:0] exp_data = '0;
   logic         mismatch;
   logic         obs_mis;
`endif

   // Chain model: flop 0 is the head (takes si), flop N-1 drives so.
   logic [N-1:0] chain_q = '0;
   logic [N-1:0] chain_d;
   int           mode = 0;
   logic [N-1:0] dv = '0;

   int n_cmp = 0;
   int n_bad = 0;

   logic         obs_se   [W];
   logic         obs_si   [W];
   logic         obs_busy [W];
   int           done_cnt, done_at, busy_cnt;
   logic [N-1:0] obs_unl_first, obs_unl_done;
   logic [N-1:0] last_exp = '0;

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .CK          (CK),
      .RN          (RN),
      .start       (start),
      .load_data   (load_data),
`ifdef SCAN_COMPARE_EN
      .exp_data    (exp_data),
      .mismatch    (mismatch),
`endif
      .so          (so),
      .se          (se),
      .si          (si),
      .busy        (busy),
      .done        (done),
      .unload_data (unload_data)
   );

   always #5 CK = ~CK;

   always_comb begin
      chain_d = chain_q;
      case (mode)
         0:       chain_d = chain_q;
         1:       chain_d = '0;
         2:       chain_d = '1;
         default: chain_d = dv;
      endcase
   end

   always @(posedge CK) chain_q <= se ? {chain_q[N-2:0], si} : chain_d;
   assign so = chain_q[N-1];

   // After a full load flop i holds ld[N-1-i]; capture replaces the chain with D;
   // the unload then reads the tail first, so bit k comes from flop N-1-k.
   function automatic logic [N-1:0] model_unload(input logic [N-1:0] ld, input int m,
                                                 input logic [N-1:0] d);
      logic [N-1:0] r;
      r = '0;
      case (m)
         0: r = ld;
         1: r = '0;
         2: r = '1;
         default: for (int i = 0; i < N; i++) r[i] = d[N-1-i];
      endcase
      return r;
   endfunction

   // Drives one sequence; observations indexed by k = cycles after the start edge.
   task automatic run_seq(input logic [N-1:0] ld, input int pulse_k);
      @(negedge CK);
      load_data = ld;
      start     = 1'b1;
      @(negedge CK);
      start    = 1'b0;
      done_cnt = 0;
      done_at  = -1;
      busy_cnt = 0;
      obs_unl_first = unload_data;
      obs_unl_done  = '0;
      for (int k = 0; k < W; k++) begin
         if (k > 0) @(negedge CK);
         obs_se[k]   = se;
         obs_si[k]   = si;
         obs_busy[k] = busy;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at      = k;
               obs_unl_done = unload_data;
`ifdef SCAN_COMPARE_EN
               obs_mis = mismatch;
`endif
            end
         end
         start = (k == pulse_k);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 RN = 1'b0;
      #1;
      n_cmp++;
      if ({se, si, busy, done, unload_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want all zero", {se, si, busy, done, unload_data});
      end
      repeat (3) @(negedge CK);
      RN = 1'b1;
   endtask

   task automatic test_load_unload();
      logic [N-1:0] ld [3];
      int           md [3];
      ld[0] = 8'hA5; md[0] = 0;
      ld[1] = 8'hFF; md[1] = 1;
      ld[2] = 8'h00; md[2] = 2;
      for (int i = 0; i < 3; i++) begin
         mode = md[i];
         run_seq(ld[i], -1);
         n_cmp++;
         if (done_at !== 2 * N + 1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL load_done_timing[%0d]: got at=%0d cnt=%0d want at=%0d cnt=1",
                     i, done_at, done_cnt, 2 * N + 1);
         end
         n_cmp++;
         if (obs_unl_done !== model_unload(ld[i], md[i], dv)) begin
            n_bad++;
            $display("FAIL load_unload[%0d]: got %h want %h", i, obs_unl_done,
                     model_unload(ld[i], md[i], dv));
         end
         n_cmp++;
         if (busy_cnt !== 2 * N + 1) begin
            n_bad++;
            $display("FAIL load_busy_len[%0d]: got %0d want %0d", i, busy_cnt, 2 * N + 1);
         end
         last_exp = model_unload(ld[i], md[i], dv);
      end
   endtask

   task automatic test_se_si();
      logic [N-1:0] ld;
      logic         exp_se, exp_si;
      ld   = 8'hA5;
      mode = 0;
      run_seq(ld, -1);
      for (int k = 0; k < W; k++) begin
         exp_se = (k < N) || (k > N && k <= 2 * N);
         exp_si = (k < N) ? ld[k] : 1'b0;
         n_cmp++;
         if (obs_se[k] !== exp_se || obs_si[k] !== exp_si) begin
            n_bad++;
            $display("FAIL se_si[k=%0d]: got se=%b si=%b want se=%b si=%b",
                     k, obs_se[k], obs_si[k], exp_se, exp_si);
         end
      end
      last_exp = ld;
   endtask

   task automatic test_ignored_start();
      int pk [2];
      pk[0] = 3;
      pk[1] = 2 * N + 1;
      mode  = 0;
      for (int i = 0; i < 2; i++) begin
         run_seq(8'h5A ^ 8'(i), pk[i]);
         n_cmp++;
         if (done_cnt !== 1 || done_at !== 2 * N + 1) begin
            n_bad++;
            $display("FAIL ignored_start[%0d]: got cnt=%0d at=%0d want cnt=1 at=%0d",
                     i, done_cnt, done_at, 2 * N + 1);
         end
         n_cmp++;
         if (obs_busy[2*N+2] !== 1'b0 || obs_busy[2*N+4] !== 1'b0 ||
             obs_unl_done !== (8'h5A ^ 8'(i))) begin
            n_bad++;
            $display("FAIL ignored_start_tail[%0d]: got busy=%b unl=%h want busy=0 unl=%h",
                     i, obs_busy[2*N+2], obs_unl_done, 8'h5A ^ 8'(i));
         end
         last_exp = 8'h5A ^ 8'(i);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] ld, want;
      logic         exp_se, exp_si;
      for (int it = 0; it < 6; it++) begin
         ld   = N'($urandom);
         mode = int'($urandom_range(0, 3));
         dv   = N'($urandom);
         want = model_unload(ld, mode, dv);
         run_seq(ld, -1);
         n_cmp++;
         if (obs_unl_first !== last_exp) begin
            n_bad++;
            $display("FAIL rand_hold[%0d]: got %h want %h", it, obs_unl_first, last_exp);
         end
         n_cmp++;
         if (obs_unl_done !== want || done_at !== 2 * N + 1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL rand_unload[%0d]: got %h at=%0d cnt=%0d want %h at=%0d cnt=1",
                     it, obs_unl_done, done_at, done_cnt, want, 2 * N + 1);
         end
         for (int k = 0; k < W; k++) begin
            exp_se = (k < N) || (k > N && k <= 2 * N);
            exp_si = (k < N) ? ld[k] : 1'b0;
            n_cmp++;
            if (obs_se[k] !== exp_se || obs_si[k] !== exp_si) begin
               n_bad++;
               $display("FAIL rand_se_si[%0d,k=%0d]: got se=%b si=%b want se=%b si=%b",
                        it, k, obs_se[k], obs_si[k], exp_se, exp_si);
            end
         end
         last_exp = want;
      end
   endtask

   task automatic test_reset_mid();
      mode = 0;
      @(negedge CK);
      load_data = 8'hC3;
      start     = 1'b1;
      @(negedge CK);
      start = 1'b0;
      repeat (N + 3) @(negedge CK);
      RN = 1'b0;
      #1;
      n_cmp++;
      if ({se, si, busy, done, unload_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got %b want all zero", {se, si, busy, done, unload_data});
      end
`ifdef SCAN_COMPARE_EN
      n_cmp++;
      if (mismatch !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_mismatch: got %b want 0", mismatch);
      end
`endif
      @(negedge CK);
      RN = 1'b1;
      last_exp = '0;
      run_seq(8'h3C, -1);
      n_cmp++;
      if (obs_unl_first !== 8'h00 || obs_unl_done !== 8'h3C || done_at !== 2 * N + 1) begin
         n_bad++;
         $display("FAIL reset_mid_restart: got first=%h unl=%h at=%0d want 00 3c %0d",
                  obs_unl_first, obs_unl_done, done_at, 2 * N + 1);
      end
      last_exp = 8'h3C;
   endtask

`ifdef SCAN_COMPARE_EN
   task automatic test_compare();
      logic [N-1:0] ex [2];
      logic         want [2];
      ex[0] = 8'hA5; want[0] = 1'b0;
      ex[1] = 8'hA4; want[1] = 1'b1;
      mode = 0;
      for (int i = 0; i < 2; i++) begin
         exp_data = ex[i];
         run_seq(8'hA5, -1);
         n_cmp++;
         if (obs_mis !== want[i] || done_at !== 2 * N + 1) begin
            n_bad++;
            $display("FAIL compare[%0d]: got mismatch=%b at=%0d want %b at=%0d",
                     i, obs_mis, done_at, want[i], 2 * N + 1);
         end
         n_cmp++;
         if (mismatch !== want[i]) begin
            n_bad++;
            $display("FAIL compare_hold[%0d]: got %b want %b", i, mismatch, want[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_unload();
      test_se_si();
      test_ignored_start();
      test_random();
      test_reset_mid();
`ifdef SCAN_COMPARE_EN
      test_compare();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
